// File: rtl/uart_tx_arbiter_pkg.sv
// Shared constants and types for the Uart8 transmit arbiter: byte width, FSM encoding,
// and the round-robin pointer advance.
package uart_tx_arbiter_pkg;

    localparam int BYTE_W = 8;

    typedef logic [BYTE_W-1:0] uartByte_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        SEND  = 2'd2
    } arbState_t;

    // Next pointer position after serving (or dropping) requester idx out of n.
    function automatic int wrapInc(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_picker.sv
// Combinational round-robin picker: first set req scanning upward from ptr, wrapping.
// Zero latency; no state, no backpressure.
module rr_picker #(
    parameter int NUM_REQ = 4,
    localparam int PTR_W = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] onehot,
    output logic [PTR_W-1:0]   index,
    output logic               valid
);

    always_comb begin
        int               cand;
        logic [PTR_W-1:0] candIdx;
        onehot  = '0;
        index   = '0;
        valid   = 1'b0;
        cand    = 0;
        candIdx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand    = (int'(ptr) + k) % NUM_REQ;
            candIdx = PTR_W'(cand);
            if (!valid && req[candIdx]) begin
                valid           = 1'b1;
                onehot[candIdx] = 1'b1;
                index           = candIdx;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin share of one Uart8 transmitter; grant/txStart one edge after req, ack one edge after txDone.
// Requesters hold req until ack; a missing txBusy within START_TIMEOUT drops the byte with an err pulse.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter int NUM_REQ       = 4,
    parameter int START_TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      en,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [BYTE_W*NUM_REQ-1:0] reqData,
    output logic [NUM_REQ-1:0]        grant,
    output logic [NUM_REQ-1:0]        ack,
    output logic                      err,
    output logic                      txEn,
    output logic                      txStart,
    output logic [BYTE_W-1:0]         txData,
    input  logic                      txBusy,
    input  logic                      txDone
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(START_TIMEOUT + 1);

    arbState_t          state;
    logic [PTR_W-1:0]   ptr;
    logic [PTR_W-1:0]   owner;
    logic [PTR_W-1:0]   ptrAfterOwner;
    logic [CNT_W-1:0]   cnt;

    logic [NUM_REQ-1:0] pickOnehot;
    logic [PTR_W-1:0]   pickIndex;
    logic               pickValid;

    uartByte_t          reqByte [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : gReqByte
        assign reqByte[g] = reqData[BYTE_W*g +: BYTE_W];
    end

    assign ptrAfterOwner = PTR_W'(wrapInc(int'(owner), NUM_REQ));

    rr_picker #(
        .NUM_REQ (NUM_REQ)
    ) picker (
        .req    (req),
        .ptr    (ptr),
        .onehot (pickOnehot),
        .index  (pickIndex),
        .valid  (pickValid)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            ptr     <= '0;
            owner   <= '0;
            cnt     <= '0;
            grant   <= '0;
            ack     <= '0;
            err     <= 1'b0;
            txEn    <= 1'b0;
            txStart <= 1'b0;
            txData  <= '0;
        end else begin
            txEn <= en;
            ack  <= '0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (en && pickValid) begin
                        grant   <= pickOnehot;
                        owner   <= pickIndex;
                        txData  <= reqByte[pickIndex];
                        txStart <= 1'b1;
                        cnt     <= '0;
                        state   <= START;
                    end
                end
                START: begin
                    if (txBusy) begin
                        txStart <= 1'b0;
                        state   <= SEND;
                    end else if (cnt == CNT_W'(START_TIMEOUT - 1)) begin
                        // Transmitter never accepted the byte: drop it and move on.
                        txStart <= 1'b0;
                        grant   <= '0;
                        err     <= 1'b1;
                        ptr     <= ptrAfterOwner;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                SEND: begin
                    // txBusy falling alone is not trusted; only txDone ends the byte.
                    if (txDone) begin
                        ack   <= grant;
                        grant <= '0;
                        ptr   <= ptrAfterOwner;
                        state <= IDLE;
                    end
                end
                default: begin
                    txStart <= 1'b0;
                    grant   <= '0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule
